// File: rtl/cpu_sram_arbiter_pkg.sv
// Shared encodings for the two-master sram-like bus arbiter.
// Defines the FSM states, the owner codes and the access size codes.
package cpu_sram_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_e;

    typedef enum logic {
        ARB_INST = 1'b0,
        ARB_DATA = 1'b1
    } arb_owner_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/cpu_sram_arbiter_if.sv
// Sram-like request/response bus.
// The master modport issues requests and the slave modport answers them.
interface cpu_sram_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, wr, size, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/cpu_sram_arbiter_rr_arb2.sv
// Two-requester round-robin picker: req_i[0] = inst, req_i[1] = data.
// On contention the requester that was not granted last wins.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       gnt_o
);
    always_comb begin
        case (req_i)
            2'b01:   gnt_o = 1'b0;
            2'b10:   gnt_o = 1'b1;
            2'b11:   gnt_o = ~last_i;
            default: gnt_o = last_i;
        endcase
    end
endmodule

// File: rtl/cpu_sram_arbiter.sv
// Shares one sram-like slave between the instruction-fetch and data masters,
// one transaction at a time, routing each response back to its owner.
//
// state    | meaning
// ARB_IDLE | no transaction outstanding, arbitrating between masters
// ARB_WAIT | one transaction accepted, its response pending
module cpu_sram_arbiter
    import cpu_sram_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    cpu_sram_arbiter_if.slave  inst_if,
    cpu_sram_arbiter_if.slave  data_if,
    cpu_sram_arbiter_if.master sram_if
);

    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q, owner_d;
    arb_owner_e        last_q, last_d;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              gnt;
    arb_owner_e        winner;
    logic              any_req;
    logic              mux_wr;
    logic [1:0]        mux_size;
    logic [ADDR_W-1:0] mux_addr;
    logic [DATA_W-1:0] mux_wdata;

    rr_arb2 u_rr_arb2 (
        .req_i  ({data_if.req, inst_if.req}),
        .last_i (last_q),
        .gnt_o  (gnt)
    );

    assign any_req   = inst_if.req | data_if.req;
    assign winner    = arb_owner_e'(gnt);
    assign mux_wr    = (winner == ARB_DATA) ? data_if.wr    : inst_if.wr;
    assign mux_size  = (winner == ARB_DATA) ? data_if.size  : inst_if.size;
    assign mux_addr  = (winner == ARB_DATA) ? data_if.addr  : inst_if.addr;
    assign mux_wdata = (winner == ARB_DATA) ? data_if.wdata : inst_if.wdata;

    assign inst_if.rdata = sram_if.rdata;
    assign data_if.rdata = sram_if.rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            owner_q <= ARB_INST;
            last_q  <= ARB_INST;
            wr_q    <= 1'b0;
            size_q  <= SIZE_B;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // The accepted request fields are kept so the slave side stays stable in WAIT.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        wr_d    = wr_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ARB_IDLE: begin
                if (any_req && sram_if.addr_ok) begin
                    state_d = ARB_WAIT;
                    owner_d = winner;
                    last_d  = winner;
                    wr_d    = mux_wr;
                    size_d  = mux_size;
                    addr_d  = mux_addr;
                    wdata_d = mux_wdata;
                end
            end
            ARB_WAIT: begin
                if (sram_if.data_ok) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        sram_if.req     = 1'b0;
        sram_if.wr      = wr_q;
        sram_if.size    = size_q;
        sram_if.addr    = addr_q;
        sram_if.wdata   = wdata_q;
        inst_if.addr_ok = 1'b0;
        data_if.addr_ok = 1'b0;
        inst_if.data_ok = 1'b0;
        data_if.data_ok = 1'b0;
        if (!reset) begin
            case (state_q)
                ARB_IDLE: begin
                    sram_if.req     = any_req;
                    sram_if.wr      = mux_wr;
                    sram_if.size    = mux_size;
                    sram_if.addr    = mux_addr;
                    sram_if.wdata   = mux_wdata;
                    inst_if.addr_ok = any_req && (winner == ARB_INST) && sram_if.addr_ok;
                    data_if.addr_ok = any_req && (winner == ARB_DATA) && sram_if.addr_ok;
                end
                ARB_WAIT: begin
                    inst_if.data_ok = sram_if.data_ok && (owner_q == ARB_INST);
                    data_if.data_ok = sram_if.data_ok && (owner_q == ARB_DATA);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Self-checking bench for cpu_sram_arbiter: directed scenarios with literal
// expectations, then random traffic checked against a transaction-level model.
module tb_cpu_sram_arbiter;

    logic clk;
    logic reset;

    cpu_sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) inst_bus ();
    cpu_sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) data_bus ();
    cpu_sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) sram_bus ();

    cpu_sram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .inst_if (inst_bus),
        .data_if (data_bus),
        .sram_if (sram_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: who holds the bus, and the history of grants.
    bit          m_busy = 1'b0;
    int          m_owner = 0;
    int          m_hist[$];
    int          m_last;
    int          m_win;
    logic        m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        e_req, e_iao, e_dao, e_ido, e_ddo;

    always @(negedge clk) begin
        e_req = 1'b0; e_iao = 1'b0; e_dao = 1'b0; e_ido = 1'b0; e_ddo = 1'b0;
        if (reset) begin
            m_busy = 1'b0;
            m_hist.delete();
        end else if (!m_busy) begin
            if (inst_bus.req || data_bus.req) begin
                m_last = (m_hist.size() == 0) ? 0 : m_hist[$];
                if (inst_bus.req && data_bus.req) m_win = 1 - m_last;
                else                              m_win = data_bus.req ? 1 : 0;
                e_req = 1'b1;
                chk("m_addr",  sram_bus.addr,  m_win == 1 ? data_bus.addr  : inst_bus.addr);
                chk("m_wr",    sram_bus.wr,    m_win == 1 ? data_bus.wr    : inst_bus.wr);
                chk("m_size",  sram_bus.size,  m_win == 1 ? data_bus.size  : inst_bus.size);
                chk("m_wdata", sram_bus.wdata, m_win == 1 ? data_bus.wdata : inst_bus.wdata);
                e_iao = (m_win == 0) && sram_bus.addr_ok;
                e_dao = (m_win == 1) && sram_bus.addr_ok;
                if (sram_bus.addr_ok) begin
                    m_busy  = 1'b1;
                    m_owner = m_win;
                    m_hist.push_back(m_win);
                    if (m_hist.size() > 4) void'(m_hist.pop_front());
                    m_wr    = sram_bus.wr;
                    m_size  = sram_bus.size;
                    m_addr  = sram_bus.addr;
                    m_wdata = sram_bus.wdata;
                end
            end
        end else begin
            chk("m_hold_addr", sram_bus.addr, m_addr);
            chk("m_hold_wr",   sram_bus.wr,   m_wr);
            chk("m_hold_size", sram_bus.size, m_size);
            chk("m_hold_wdat", sram_bus.wdata, m_wdata);
            if (sram_bus.data_ok) begin
                e_ido  = (m_owner == 0);
                e_ddo  = (m_owner == 1);
                m_busy = 1'b0;
            end
        end
        chk("m_req",          sram_bus.req,      e_req);
        chk("m_inst_addr_ok", inst_bus.addr_ok,  e_iao);
        chk("m_data_addr_ok", data_bus.addr_ok,  e_dao);
        chk("m_inst_data_ok", inst_bus.data_ok,  e_ido);
        chk("m_data_data_ok", data_bus.data_ok,  e_ddo);
        if (e_ido) chk("m_inst_rdata", inst_bus.rdata, sram_bus.rdata);
        if (e_ddo) chk("m_data_rdata", data_bus.rdata, sram_bus.rdata);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic idle_inputs;
        inst_bus.req = 1'b0; inst_bus.wr = 1'b0; inst_bus.size = 2'd2;
        inst_bus.addr = '0;  inst_bus.wdata = '0;
        data_bus.req = 1'b0; data_bus.wr = 1'b0; data_bus.size = 2'd2;
        data_bus.addr = '0;  data_bus.wdata = '0;
        sram_bus.addr_ok = 1'b0; sram_bus.data_ok = 1'b0; sram_bus.rdata = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset = 1'b1;
        repeat (3) tick();
        settle();
        chk("rst_req", sram_bus.req, 1'b0);
        chk("rst_inst_addr_ok", inst_bus.addr_ok, 1'b0);
        chk("rst_data_addr_ok", data_bus.addr_ok, 1'b0);
        reset = 1'b0;
        tick();
    endtask

    localparam logic [31:0] IADDR = 32'hbfc0_0100;
    localparam logic [31:0] DADDR = 32'h8000_1000;

    int  pulses;
    bit  exp_data;

    initial begin
        reset = 1'b1;
        idle_inputs();
        do_reset();

        // Inst-only read
        inst_bus.req = 1'b1; inst_bus.addr = 32'hbfc0_0000; sram_bus.addr_ok = 1'b1;
        settle();
        chk("io_inst_addr_ok", inst_bus.addr_ok, 1'b1);
        chk("io_data_addr_ok", data_bus.addr_ok, 1'b0);
        chk("io_addr", sram_bus.addr, 32'hbfc0_0000);
        tick();
        inst_bus.req = 1'b0; sram_bus.addr_ok = 1'b0;
        settle();
        chk("io_c1_inst_data_ok", inst_bus.data_ok, 1'b0);
        tick();
        sram_bus.data_ok = 1'b1; sram_bus.rdata = 32'h3c1d_0001;
        settle();
        chk("io_inst_data_ok", inst_bus.data_ok, 1'b1);
        chk("io_inst_rdata", inst_bus.rdata, 32'h3c1d_0001);
        chk("io_data_data_ok", data_bus.data_ok, 1'b0);
        tick();
        sram_bus.data_ok = 1'b0;

        // Contention from reset: data, inst, data, inst
        do_reset();
        inst_bus.req = 1'b1; inst_bus.addr = IADDR;
        data_bus.req = 1'b1; data_bus.addr = DADDR;
        sram_bus.addr_ok = 1'b1; sram_bus.data_ok = 1'b1;
        for (int c = 0; c < 8; c++) begin
            settle();
            if (c % 2 == 0) begin
                exp_data = ((c / 2) % 2 == 0);
                chk("ct_data_addr_ok", data_bus.addr_ok, exp_data);
                chk("ct_inst_addr_ok", inst_bus.addr_ok, !exp_data);
                chk("ct_addr", sram_bus.addr, exp_data ? DADDR : IADDR);
            end else begin
                chk("ct_wait_req", sram_bus.req, 1'b0);
            end
            tick();
        end

        // Data byte write
        inst_bus.req = 1'b0;
        data_bus.req = 1'b1; data_bus.wr = 1'b1; data_bus.size = 2'd0;
        data_bus.addr = 32'h1faf_0001; data_bus.wdata = 32'h0000_00ab;
        sram_bus.addr_ok = 1'b1; sram_bus.data_ok = 1'b0;
        settle();
        chk("dw_wr", sram_bus.wr, 1'b1);
        chk("dw_size", sram_bus.size, 2'd0);
        chk("dw_addr", sram_bus.addr, 32'h1faf_0001);
        chk("dw_wdata", sram_bus.wdata, 32'h0000_00ab);
        chk("dw_data_addr_ok", data_bus.addr_ok, 1'b1);
        pulses = 0;
        tick();
        data_bus.req = 1'b0; data_bus.wr = 1'b0; sram_bus.addr_ok = 1'b0; sram_bus.data_ok = 1'b1;
        settle();
        pulses += int'(data_bus.data_ok);
        tick();
        sram_bus.data_ok = 1'b0;
        settle();
        pulses += int'(data_bus.data_ok);
        tick();
        settle();
        pulses += int'(data_bus.data_ok);
        chk("dw_pulses", pulses, 1);

        // Stalled slave; late data request loses because data was granted last
        tick();
        inst_bus.req = 1'b1; inst_bus.addr = IADDR; sram_bus.addr_ok = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                data_bus.req = 1'b1; data_bus.addr = DADDR;
            end
            settle();
            chk("st_req", sram_bus.req, 1'b1);
            chk("st_inst_addr_ok", inst_bus.addr_ok, 1'b0);
            chk("st_data_addr_ok", data_bus.addr_ok, 1'b0);
            if (k >= 2) chk("st_addr", sram_bus.addr, IADDR);
            tick();
        end
        sram_bus.addr_ok = 1'b1;
        settle();
        chk("st_grant_inst", inst_bus.addr_ok, 1'b1);
        chk("st_grant_data", data_bus.addr_ok, 1'b0);
        tick();

        // Blocking while WAIT
        data_bus.req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            settle();
            chk("bl_req", sram_bus.req, 1'b0);
            chk("bl_inst_addr_ok", inst_bus.addr_ok, 1'b0);
            tick();
        end
        sram_bus.data_ok = 1'b1; sram_bus.rdata = 32'h1234_5678;
        settle();
        chk("bl_inst_data_ok", inst_bus.data_ok, 1'b1);
        chk("bl_inst_addr_ok_resp", inst_bus.addr_ok, 1'b0);
        tick();
        sram_bus.data_ok = 1'b0;
        settle();
        chk("bl_next_idle_ok", inst_bus.addr_ok, 1'b1);
        tick();

        // Reset while WAIT drops the pending response
        reset = 1'b1; inst_bus.req = 1'b0; sram_bus.addr_ok = 1'b0;
        settle();
        chk("rw_req", sram_bus.req, 1'b0);
        tick();
        reset = 1'b0; sram_bus.data_ok = 1'b1;
        settle();
        chk("rw_inst_data_ok", inst_bus.data_ok, 1'b0);
        chk("rw_data_data_ok", data_bus.data_ok, 1'b0);
        tick();
        sram_bus.data_ok = 1'b0; inst_bus.req = 1'b1; data_bus.req = 1'b1; sram_bus.addr_ok = 1'b1;
        settle();
        chk("rw_idle_data_wins", data_bus.addr_ok, 1'b1);
        chk("rw_idle_inst_loses", inst_bus.addr_ok, 1'b0);
        tick();
        inst_bus.req = 1'b0; data_bus.req = 1'b0; sram_bus.addr_ok = 1'b0; sram_bus.data_ok = 1'b1;
        tick();
        sram_bus.data_ok = 1'b0;

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            reset            = ($urandom_range(0, 99) == 0);
            inst_bus.req     = ($urandom_range(0, 9) < 6);
            inst_bus.wr      = 1'($urandom_range(0, 1));
            inst_bus.size    = 2'($urandom_range(0, 2));
            inst_bus.addr    = $urandom;
            inst_bus.wdata   = $urandom;
            data_bus.req     = ($urandom_range(0, 9) < 6);
            data_bus.wr      = 1'($urandom_range(0, 1));
            data_bus.size    = 2'($urandom_range(0, 2));
            data_bus.addr    = $urandom;
            data_bus.wdata   = $urandom;
            sram_bus.addr_ok = 1'($urandom_range(0, 1));
            sram_bus.data_ok = ($urandom_range(0, 9) < 4);
            sram_bus.rdata   = $urandom;
            tick();
        end

        reset = 1'b0;
        idle_inputs();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/cpu_sram_arbiter.md
# cpu_sram_arbiter

Two-master, one-slave arbiter for sram-like buses. It lets the instruction-fetch port (driven by `if_stage` through the pre-IF request) and the data port of the MEM stage share a single sram-like slave interface, which feeds the later AXI bridge. It issues one transaction at a time, routes each response back to the master that owns it, and alternates between masters when both are requesting.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width, in bits.
- `clk` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `inst_req`/`data_req` in 1: master request.
- `inst_wr`/`data_wr` in 1: 1 = write.
- `inst_size`/`data_size` in 2: 0 = byte, 1 = half, 2 = word.
- `inst_addr`/`data_addr` in ADDR_W: request address.
- `inst_wdata`/`data_wdata` in DATA_W: write data.
- `inst_addr_ok`/`data_addr_ok` out 1: request accepted this cycle.
- `inst_data_ok`/`data_data_ok` out 1: response valid this cycle.
- `inst_rdata`/`data_rdata` out DATA_W: read data.
- `req` out 1: slave-side request.
- `wr` out 1: slave-side write flag.
- `size` out 2: slave-side size.
- `addr` out ADDR_W: slave-side address.
- `wdata` out DATA_W: slave-side write data.
- `addr_ok` in 1: slave accepted the request.
- `data_ok` in 1: slave response valid.
- `rdata` in DATA_W: slave read data.

## Operation
- FSM states:
  - IDLE: no transaction outstanding.
  - WAIT: one transaction accepted, its response pending.
- Registers:
  - `state`.
  - `owner`: 0 = inst, 1 = data.
  - `last_grant`: same encoding as `owner`.
- IDLE grant rule:
  - Only one master requesting: that master wins.
  - Both requesting: the master other than `last_grant` wins.
  - Reset value of `last_grant` = inst, so the first contention goes to data.
- IDLE slave drive: combinationally drive `req`, `wr`, `size`, `addr`, `wdata` from the winning master. `req` = `inst_req | data_req`.
- `addr_ok` is routed combinationally to the winning master only. The loser's `addr_ok` = 0.
- IDLE with `req && addr_ok`: go to WAIT, `owner` <= winner, `last_grant` <= winner.
- WAIT:
  - `req` = 0.
  - Both masters' `addr_ok` = 0.
  - `wr`, `size`, `addr`, `wdata` are don't-care; hold the last values.
- WAIT with `data_ok`:
  - Pulse `owner`'s `*_data_ok` for one cycle, with `*_rdata` = `rdata`.
  - Go to IDLE.
  - The non-owner's `data_ok` is never asserted.
- Write transactions return `data_ok` the same way; `rdata` is ignored by masters.
- `*_rdata` is a combinational pass-through of `rdata`; values are only meaningful while the matching `data_ok` is high.
- Slave `data_ok` while in IDLE is a protocol error: ignore it and assert nothing.
- Masters may drop or change their request while not yet accepted. Arbitration is re-evaluated every IDLE cycle.
- No exception flush input. A redirect in the fetch unit is handled upstream by discarding the returned instruction; the arbiter always completes the transaction.

## Timing
- Reset:
  - `state` = IDLE, `owner` = inst, `last_grant` = inst.
  - While `reset` is high, all outputs `req`, `*_addr_ok`, `*_data_ok` = 0.
- Accept: 0-cycle combinational path from master `*_req` to slave `req`, and from slave `addr_ok` to master `*_addr_ok`.
- Response: `*_data_ok` is asserted in the same cycle as slave `data_ok`, combinational.
- Slave `data_ok` is earliest 1 cycle after `addr_ok`. Each transaction therefore takes at least 2 cycles, and back-to-back throughput is at most one transaction per 2 cycles.
- The next request can be issued in the IDLE cycle right after `data_ok`.
- Reset mid-transaction: return to IDLE the next edge, drop the outstanding response, and assert no `data_ok`. The slave must be reset on the same edge.
- Simultaneous requests in IDLE: exactly one master receives `addr_ok`, never both.

## Structure
- Shared header (`mycpu.h`) gets:
  - state encodings `ARB_IDLE`/`ARB_WAIT`;
  - owner codes `ARB_INST`/`ARB_DATA`;
  - size codes `SIZE_B`/`SIZE_H`/`SIZE_W`.
- One natural sub-module: `rr_arb2`, a 2-requester round-robin picker (inputs `req[1:0]`, `last`; output `gnt`). Everything else stays in `cpu_sram_arbiter`.

## Test plan
- Inst only: `inst_req`=1, `inst_addr`=0xbfc00000; slave `addr_ok` in cycle 0, `data_ok`=1 with `rdata`=0x3c1d0001 in cycle 2 -> `inst_addr_ok` in cycle 0, `inst_data_ok` with `inst_rdata`=0x3c1d0001 in cycle 2, `data_*_ok` stay 0 throughout.
- Contention: both masters request continuously, slave answers in 1 cycle -> grants alternate data, inst, data, inst, starting from reset, each with the matching address on `addr`.
- Data write: `data_wr`=1, `data_size`=0, `data_addr`=0x1faf0001, `data_wdata`=0xAB -> slave sees `wr`=1, `size`=0 and the same addr/wdata. `data_data_ok` pulses exactly once.
- Stalled slave: `addr_ok` held low for 5 cycles -> `req` stays 1 and no `*_addr_ok` is asserted. A second master arriving during those cycles may take the grant only per the round-robin rule.
- Blocking: while in WAIT, assert `inst_req` -> `req`=0 and `inst_addr_ok`=0 until `data_ok`. `inst_addr_ok` is asserted in the following IDLE cycle.
- Reset in WAIT: then slave `data_ok`=1 after reset -> no `*_data_ok` pulse, and state is IDLE.
